// File: rtl/alu_ctrl_mdu.sv
// ALU control decode with an iterative multiply/divide unit holding HI/LO.
// Divide support (div/divu, DIV state, div0 flag) is built only when ALU_CTRL_MDU_DIV_EN is defined.
module alu_ctrl_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ALUOp,
    input  logic [5:0]       func,
    input  logic             valid,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [3:0]       ALU_control,
    output logic             JumpReg,
    output logic             illegal,
    output logic             stall,
    output logic             busy,
    output logic             mdu_rd_en,
    output logic [WIDTH-1:0] mdu_rd,
    output logic             div0
);
    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef ALU_CTRL_MDU_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, FIX = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, FIX = 2'd3} state_t;
`endif

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   acc_q, reg_a_q, reg_b_q;
    logic               neg_res_q;

    logic is_r, is_mult, is_multu, is_mfhi, is_mflo, is_mdu_op, is_signed, accept;
    logic a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    always_comb begin
        ALU_control = 4'b0010;
        JumpReg     = 1'b0;
        illegal     = 1'b0;
        case (ALUOp)
            3'b001: ALU_control = 4'b0110;
            3'b011: ALU_control = 4'b0000;
            3'b100: ALU_control = 4'b0001;
            3'b010: begin
                case (func)
                    6'h20: ALU_control = 4'b0010;
                    6'h22: ALU_control = 4'b0110;
                    6'h24: ALU_control = 4'b0000;
                    6'h25: ALU_control = 4'b0001;
                    6'h26: ALU_control = 4'b0011;
                    6'h27: ALU_control = 4'b1100;
                    6'h2A: ALU_control = 4'b0111;
                    6'h2B: ALU_control = 4'b1000;
                    6'h00: ALU_control = 4'b1111;
                    6'h02: ALU_control = 4'b1110;
                    6'h08: begin
                        ALU_control = 4'b0000;
                        JumpReg     = 1'b1;
                    end
                    6'h18, 6'h19, 6'h10, 6'h12: ALU_control = 4'b0010;
`ifdef ALU_CTRL_MDU_DIV_EN
                    6'h1A, 6'h1B: ALU_control = 4'b0010;
`endif
                    default: illegal = 1'b1;
                endcase
            end
            default: ALU_control = 4'b0010;
        endcase
    end

    assign is_r     = (ALUOp == 3'b010);
    assign is_mult  = is_r && (func == 6'h18);
    assign is_multu = is_r && (func == 6'h19);
    assign is_mfhi  = is_r && (func == 6'h10);
    assign is_mflo  = is_r && (func == 6'h12);

`ifdef ALU_CTRL_MDU_DIV_EN
    logic is_div, is_divu, is_div_op;
    assign is_div    = is_r && (func == 6'h1A);
    assign is_divu   = is_r && (func == 6'h1B);
    assign is_div_op = is_div || is_divu;
    assign is_mdu_op = is_mult || is_multu || is_div_op;
    assign is_signed = is_mult || is_div;
`else
    assign is_mdu_op = is_mult || is_multu;
    assign is_signed = is_mult;
`endif

    assign mdu_rd_en = is_mfhi || is_mflo;
    assign mdu_rd    = is_mfhi ? hi_q : lo_q;
    assign busy      = busy_q;
    assign stall     = valid && busy_q && (is_mdu_op || mdu_rd_en);
    assign accept    = valid && (state == IDLE) && is_mdu_op;

    // Signed ops iterate on magnitudes; signs are reapplied in FIX.
    assign a_neg = is_signed && src_a[WIDTH-1];
    assign b_neg = is_signed && src_b[WIDTH-1];
    assign a_abs = a_neg ? neg_w(src_a) : src_a;
    assign b_abs = b_neg ? neg_w(src_b) : src_b;

    assign mul_sum = {1'b0, acc_q} + (reg_a_q[0] ? {1'b0, reg_b_q} : {(WIDTH+1){1'b0}});

`ifdef ALU_CTRL_MDU_DIV_EN
    logic             neg_rem_q, op_div_q, div_zero_q, div0_q, div_ok;
    logic [WIDTH:0]   div_shift, div_diff;
    assign div_shift = {acc_q, reg_a_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, reg_b_q};
    assign div_ok    = !div_diff[WIDTH];
    assign div0      = div0_q;
`else
    assign div0      = 1'b0;
`endif

    always_comb begin
        prod = {acc_q, reg_a_q};
        if (neg_res_q) prod = neg_dw(prod);
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef ALU_CTRL_MDU_DIV_EN
        if (op_div_q) begin
            if (div_zero_q) begin
                fix_lo = '1;
                fix_hi = reg_a_q;
            end else begin
                fix_lo = neg_res_q ? neg_w(reg_a_q) : reg_a_q;
                fix_hi = neg_rem_q ? neg_w(acc_q) : acc_q;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
`ifdef ALU_CTRL_MDU_DIV_EN
            div0_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        cnt    <= CNT_W'(WIDTH);
                        state  <= MUL;
`ifdef ALU_CTRL_MDU_DIV_EN
                        if (is_div_op) begin
                            if (src_b == '0) begin
                                state <= FIX;
                                cnt   <= '0;
                            end else begin
                                state <= DIV;
                            end
                        end
`endif
                    end
                end
                MUL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
`ifdef ALU_CTRL_MDU_DIV_EN
                DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) state <= FIX;
                end
`endif
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    hi_q   <= fix_hi;
                    lo_q   <= fix_lo;
`ifdef ALU_CTRL_MDU_DIV_EN
                    if (op_div_q) div0_q <= div_zero_q;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand latch on accept, then one shift-add or restoring step per cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc_q     <= '0;
            reg_a_q   <= a_abs;
            reg_b_q   <= b_abs;
            neg_res_q <= a_neg ^ b_neg;
`ifdef ALU_CTRL_MDU_DIV_EN
            neg_rem_q  <= a_neg;
            op_div_q   <= is_div_op;
            div_zero_q <= is_div_op && (src_b == '0);
            if (is_div_op && (src_b == '0)) reg_a_q <= src_a;
`endif
        end else if (state == MUL) begin
            acc_q   <= mul_sum[WIDTH:1];
            reg_a_q <= {mul_sum[0], reg_a_q[WIDTH-1:1]};
        end
`ifdef ALU_CTRL_MDU_DIV_EN
        else if (state == DIV) begin
            acc_q   <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            reg_a_q <= {reg_a_q[WIDTH-2:0], div_ok};
        end
`endif
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Directed bench for alu_ctrl_mdu: decode table, multiply/divide results, stall and reset behaviour.
`timescale 1ns/1ps
module tb_alu_ctrl_mdu;
    localparam int W = 32;
`ifdef ALU_CTRL_MDU_DIV_EN
    localparam logic DIV_ILL = 1'b0;
`else
    localparam logic DIV_ILL = 1'b1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [2:0]   ALUOp = 3'b000;
    logic [5:0]   func = 6'h00;
    logic         valid = 1'b0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic [3:0]   ALU_control;
    logic         JumpReg, illegal, stall, busy, mdu_rd_en, div0;
    logic [W-1:0] mdu_rd;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [2:0] op;
        logic [5:0] fn;
        logic [3:0] ctl;
        logic       jr;
        logic       ill;
        logic       en;
    } dec_t;

    always #5 clk = ~clk;

    alu_ctrl_mdu #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOp(ALUOp), .func(func), .valid(valid),
        .src_a(src_a), .src_b(src_b), .ALU_control(ALU_control), .JumpReg(JumpReg),
        .illegal(illegal), .stall(stall), .busy(busy), .mdu_rd_en(mdu_rd_en),
        .mdu_rd(mdu_rd), .div0(div0)
    );

    // Advance n rising edges and settle 1ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    // Present an R-type MDU op for one edge (the accept edge), then drop valid.
    task automatic start_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp = 3'b010; func = fn; src_a = a; src_b = b; valid = 1'b1;
        tick(1);
        valid = 1'b0;
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        ALUOp = 3'b010; valid = 1'b0;
        func = 6'h10; #1 hi = mdu_rd;
        func = 6'h12; #1 lo = mdu_rd;
    endtask

    task automatic test_reset;
        logic [W-1:0] v;
        ALUOp = 3'b010; func = 6'h10; valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (div0 !== 1'b0) begin miscompares++; $display("FAIL reset_div0: got %b want 0", div0); end
        vectors++; if (mdu_rd !== '0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", mdu_rd); end
        func = 6'h12; #1 v = mdu_rd;
        vectors++; if (v !== '0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", v); end
        func = 6'h18; valid = 1'b1; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b want 0", stall); end
        valid = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_decode;
        dec_t tbl [30];
        tbl = '{
            '{3'b000, 6'h08, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b001, 6'h08, 4'b0110, 1'b0, 1'b0, 1'b0},
            '{3'b011, 6'h20, 4'b0000, 1'b0, 1'b0, 1'b0},
            '{3'b100, 6'h20, 4'b0001, 1'b0, 1'b0, 1'b0},
            '{3'b101, 6'h08, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b110, 6'h2A, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b111, 6'h12, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h20, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h22, 4'b0110, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h24, 4'b0000, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h25, 4'b0001, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h26, 4'b0011, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h27, 4'b1100, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h2A, 4'b0111, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h2B, 4'b1000, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h00, 4'b1111, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h02, 4'b1110, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h08, 4'b0000, 1'b1, 1'b0, 1'b0},
            '{3'b010, 6'h3F, 4'b0010, 1'b0, 1'b1, 1'b0},
            '{3'b010, 6'h01, 4'b0010, 1'b0, 1'b1, 1'b0},
            '{3'b010, 6'h18, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h19, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b010, 6'h10, 4'b0010, 1'b0, 1'b0, 1'b1},
            '{3'b010, 6'h12, 4'b0010, 1'b0, 1'b0, 1'b1},
            '{3'b010, 6'h1A, 4'b0010, 1'b0, DIV_ILL, 1'b0},
            '{3'b010, 6'h1B, 4'b0010, 1'b0, DIV_ILL, 1'b0},
            '{3'b010, 6'h11, 4'b0010, 1'b0, 1'b1, 1'b0},
            '{3'b010, 6'h09, 4'b0010, 1'b0, 1'b1, 1'b0},
            '{3'b101, 6'h3F, 4'b0010, 1'b0, 1'b0, 1'b0},
            '{3'b111, 6'h08, 4'b0010, 1'b0, 1'b0, 1'b0}
        };
        valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            ALUOp = tbl[i].op; func = tbl[i].fn;
            #1;
            vectors++; if (ALU_control !== tbl[i].ctl) begin miscompares++;
                $display("FAIL dec_ctl[%0d] op=%b fn=%h: got %b want %b", i, tbl[i].op, tbl[i].fn, ALU_control, tbl[i].ctl); end
            vectors++; if (JumpReg !== tbl[i].jr) begin miscompares++;
                $display("FAIL dec_jr[%0d]: got %b want %b", i, JumpReg, tbl[i].jr); end
            vectors++; if (illegal !== tbl[i].ill) begin miscompares++;
                $display("FAIL dec_illegal[%0d]: got %b want %b", i, illegal, tbl[i].ill); end
            vectors++; if (mdu_rd_en !== tbl[i].en) begin miscompares++;
                $display("FAIL dec_rd_en[%0d]: got %b want %b", i, mdu_rd_en, tbl[i].en); end
        end
        ALUOp = 3'b010; func = 6'h2A; valid = 1'b1; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL slt_stall: got %b want 0", stall); end
        valid = 1'b0;
        tick(1);
    endtask

    // -3 * 7 = -21; an mfhi presented 5 edges after accept holds in stall until busy drops.
    task automatic test_mult;
        logic [W-1:0] hi, lo;
        start_op(6'h18, 32'hFFFF_FFFD, 32'h0000_0007);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy_start: got %b want 1", busy); end
        func = 6'h20;
        for (int k = 1; k <= W + 1; k++) begin
            tick(1);
            if (k == 3) begin
                func = 6'h20; valid = 1'b1; #1;
                vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL add_while_busy_stall: got %b want 0", stall); end
            end
            if (k == 5) begin func = 6'h10; valid = 1'b1; #1; end
            if (k >= 5 && k <= W) begin
                vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL mfhi_stall k=%0d: got %b want 1", k, stall); end
            end
            if (k == W) begin
                vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mult_busy_late: got %b want 1", busy); end
            end
        end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mult_busy_end: got %b want 0", busy); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mfhi_stall_end: got %b want 0", stall); end
        vectors++; if (mdu_rd !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_mfhi: got %h want FFFFFFFF", mdu_rd); end
        read_hilo(hi, lo);
        vectors++; if (lo !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mult_lo: got %h want FFFFFFEB", lo); end
        tick(1);
    endtask

    // A second multu held under stall is accepted on the edge after busy falls.
    task automatic test_back_to_back;
        logic [W-1:0] hi, lo;
        int n;
        start_op(6'h19, 32'd6, 32'd7);
        func = 6'h19; src_a = 32'd3; src_b = 32'd5; valid = 1'b1; #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL b2b_stall: got %b want 1", stall); end
        n = 0;
        while (busy === 1'b1 && n < W + 4) begin
            @(posedge clk); #1; n++;
        end
        vectors++; if (n !== W + 1) begin miscompares++; $display("FAIL b2b_latency: got %0d edges want %0d", n, W + 1); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall_release: got %b want 0", stall); end
        vectors++; if (mdu_rd !== 32'd42) begin miscompares++; $display("FAIL b2b_first_lo: got %h want 2A", mdu_rd); end
        tick(1);
        valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept: got %b want 1", busy); end
        tick(W + 1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_second_busy: got %b want 0", busy); end
        read_hilo(hi, lo);
        vectors++; if (hi !== '0) begin miscompares++; $display("FAIL b2b_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd15) begin miscompares++; $display("FAIL b2b_lo: got %h want F", lo); end
        tick(1);
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] hi, lo;
        start_op(6'h18, 32'hFFFF_FFFD, 32'h0000_0007);
        func = 6'h12;
        tick(10);
        rst_n = 1'b0; #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        vectors++; if (mdu_rd !== '0) begin miscompares++; $display("FAIL rstmid_lo: got %h want 0", mdu_rd); end
        func = 6'h10; #1;
        vectors++; if (mdu_rd !== '0) begin miscompares++; $display("FAIL rstmid_hi: got %h want 0", mdu_rd); end
        tick(2);
        rst_n = 1'b1;
        start_op(6'h19, 32'd2, 32'd3);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_first_accept: got %b want 1", busy); end
        tick(W - 5);
        vectors++; if (mdu_rd !== '0) begin miscompares++; $display("FAIL rst_abandoned_write: got %h want 0", mdu_rd); end
        tick(6);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_op_busy: got %b want 0", busy); end
        read_hilo(hi, lo);
        vectors++; if (hi !== '0) begin miscompares++; $display("FAIL rst_op_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL rst_op_lo: got %h want 6", lo); end
        tick(1);
    endtask

`ifdef ALU_CTRL_MDU_DIV_EN
    task automatic test_div;
        logic [W-1:0] hi, lo;
        start_op(6'h1B, 32'd100, 32'd7);
        tick(W);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL divu_busy_late: got %b want 1", busy); end
        tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL divu_busy_end: got %b want 0", busy); end
        read_hilo(hi, lo);
        vectors++; if (lo !== 32'd14) begin miscompares++; $display("FAIL divu_lo: got %h want E", lo); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL divu_hi: got %h want 2", hi); end
        vectors++; if (div0 !== 1'b0) begin miscompares++; $display("FAIL divu_div0: got %b want 0", div0); end
        tick(1);
        start_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
        tick(W + 1);
        read_hilo(hi, lo);
        vectors++; if (lo !== 32'hFFFF_FFFD) begin miscompares++; $display("FAIL div_neg_lo: got %h want FFFFFFFD", lo); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div_neg_hi: got %h want FFFFFFFF", hi); end
        tick(1);
        start_op(6'h1A, 32'd5, 32'd0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL div0_busy: got %b want 1", busy); end
        tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL div0_busy_end: got %b want 0", busy); end
        vectors++; if (div0 !== 1'b1) begin miscompares++; $display("FAIL div0_flag: got %b want 1", div0); end
        read_hilo(hi, lo);
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL div0_lo: got %h want FFFFFFFF", lo); end
        vectors++; if (hi !== 32'd5) begin miscompares++; $display("FAIL div0_hi: got %h want 5", hi); end
        tick(1);
        start_op(6'h19, 32'd2, 32'd3);
        tick(W + 1);
        vectors++; if (div0 !== 1'b1) begin miscompares++; $display("FAIL mult_keeps_div0: got %b want 1", div0); end
        start_op(6'h1B, 32'd9, 32'd3);
        tick(W + 1);
        vectors++; if (div0 !== 1'b0) begin miscompares++; $display("FAIL div0_clear: got %b want 0", div0); end
        read_hilo(hi, lo);
        vectors++; if (lo !== 32'd3) begin miscompares++; $display("FAIL divu93_lo: got %h want 3", lo); end
        vectors++; if (hi !== '0) begin miscompares++; $display("FAIL divu93_hi: got %h want 0", hi); end
        tick(1);
    endtask
`else
    // HI=0, LO=6 from the previous scenario; a divide must not disturb them.
    task automatic test_div_disabled;
        logic [W-1:0] hi, lo;
        ALUOp = 3'b010; func = 6'h1A; src_a = 32'd8; src_b = 32'd2; valid = 1'b1; #1;
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL nodiv_illegal: got %b want 1", illegal); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL nodiv_stall: got %b want 0", stall); end
        tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nodiv_busy: got %b want 0", busy); end
        vectors++; if (div0 !== 1'b0) begin miscompares++; $display("FAIL nodiv_div0: got %b want 0", div0); end
        func = 6'h1B; #1;
        vectors++; if (illegal !== 1'b1) begin miscompares++; $display("FAIL nodivu_illegal: got %b want 1", illegal); end
        valid = 1'b0;
        read_hilo(hi, lo);
        vectors++; if (hi !== '0) begin miscompares++; $display("FAIL nodiv_hi: got %h want 0", hi); end
        vectors++; if (lo !== 32'd6) begin miscompares++; $display("FAIL nodiv_lo: got %h want 6", lo); end
        tick(1);
        start_op(6'h19, 32'd5, 32'd5);
        func = 6'h1A; valid = 1'b1; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL nodiv_busy_stall: got %b want 0", stall); end
        tick(W + 1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nodiv_mult_busy: got %b want 0", busy); end
        vectors++; if (mdu_rd !== 32'd25) begin miscompares++; $display("FAIL nodiv_mult_lo: got %h want 19", mdu_rd); end
        tick(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL nodiv_no_start: got %b want 0", busy); end
        valid = 1'b0;
        tick(1);
    endtask
`endif

    initial begin
        test_reset;
        test_decode;
        test_mult;
        test_back_to_back;
        test_reset_mid;
`ifdef ALU_CTRL_MDU_DIV_EN
        test_div;
`else
        test_div_disabled;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
